// File: rtl/cpu_port_bridge.sv
// CPU I/O port endpoint: buffers CPU output strobes in a first-word-fall-through FIFO
// drained over valid/ready, and latches external valid/ready words onto the CPU input port.
module cpu_port_bridge #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   cpu_out_port,
    input  logic          cpu_output_valid,
    output logic [15:0]   cpu_in_port,
    output logic [15:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic [15:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          ovf_clr,
    output logic [CW-1:0] level,
    output logic          overflow,
    output logic [7:0]    drop_count
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [15:0]   hold;
    logic          rdy;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    always_comb begin
        pop  = (count != '0) & m_ready;
        full = (count == CW'(DEPTH));
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push = cpu_output_valid & (~full | pop);
        drop = cpu_output_valid & ~push;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= cpu_out_port;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A drop coinciding with a clear is still counted, so the count reloads to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy  <= 1'b0;
            hold <= '0;
        end else begin
            rdy <= 1'b1;
            if (s_valid && rdy) begin
                hold <= s_data;
            end
        end
    end

    always_comb begin
        m_data      = mem[rptr];
        m_valid     = (count != '0);
        level       = count;
        cpu_in_port = hold;
        s_ready     = rdy;
    end
endmodule

// File: tb/tb_cpu_port_bridge.sv
// Bench for cpu_port_bridge: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_cpu_port_bridge;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   cpu_out_port = '0;
    logic          cpu_output_valid = 1'b0;
    logic [15:0]   cpu_in_port;
    logic [15:0]   m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [15:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    cpu_port_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_out_port(cpu_out_port), .cpu_output_valid(cpu_output_valid),
        .cpu_in_port(cpu_in_port),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ovf_clr(ovf_clr), .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus counters.
    logic [15:0]  mq[$];
    int unsigned  m_dc = 0;
    bit           m_ovf = 0;
    logic [15:0]  m_in = '0;
    bit           m_rdy = 0;

    always @(posedge clk or posedge rst) begin
        bit do_pop;
        bit do_drop;
        int sz;
        if (rst) begin
            mq.delete();
            m_dc  = 0;
            m_ovf = 0;
            m_in  = '0;
            m_rdy = 0;
        end else begin
            sz      = mq.size();
            do_pop  = (sz != 0) && m_ready;
            do_drop = cpu_output_valid && (sz >= DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (cpu_output_valid && !do_drop) mq.push_back(cpu_out_port);
            if (ovf_clr) begin
                m_ovf = 0;
                m_dc  = do_drop ? 1 : 0;
            end else if (do_drop) begin
                m_ovf = 1;
                m_dc  = (m_dc >= 255) ? 255 : m_dc + 1;
            end
            if (s_valid && m_rdy) m_in = s_data;
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), m_dc);
            chk("cpu_in_port", 32'(cpu_in_port), 32'(m_in));
            chk("s_ready", 32'(s_ready), 32'(m_rdy));
        end
    end

    // Sets inputs, lets one rising edge apply them, returns 1 time unit after it.
    task automatic drive(input bit v, input logic [15:0] d, input bit mr, input bit clr,
                         input bit sv, input logic [15:0] sd);
        cpu_output_valid = v;
        cpu_out_port     = d;
        m_ready          = mr;
        ovf_clr          = clr;
        s_valid          = sv;
        s_data           = sd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_cpu_in_port", 32'(cpu_in_port), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_release", 32'(s_ready), 1);

        drive(1, 16'h1111, 0, 0, 0, 0);
        chk("first_word_visible", 32'(m_data), 32'h1111);
        drive(1, 16'h2222, 0, 0, 0, 0);
        drive(1, 16'h3333, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("order_level", 32'(level), 3);
        chk("order_head", 32'(m_data), 32'h1111);
        drive(0, 0, 1, 0, 0, 0);
        chk("order_pop2", 32'(m_data), 32'h2222);
        drive(0, 0, 1, 0, 0, 0);
        chk("order_pop3", 32'(m_data), 32'h3333);
        drive(0, 0, 1, 0, 0, 0);
        chk("order_empty_level", 32'(level), 0);
        chk("order_empty_valid", 32'(m_valid), 0);

        for (int i = 0; i < 10; i++) drive(1, 16'(i), 0, 0, 0, 0);
        chk("ovf_level", 32'(level), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(drop_count), 2);

        chk("full_head", 32'(m_data), 32'h0000);
        drive(1, 16'hABCD, 1, 0, 0, 0);
        chk("full_pushpop_level", 32'(level), 8);
        chk("full_pushpop_nodrop", 32'(drop_count), 2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_word", 32'(m_data), (i < 7) ? 32'(i + 1) : 32'hABCD);
            drive(0, 0, 1, 0, 0, 0);
        end
        chk("drain_level", 32'(level), 0);

        for (int i = 0; i < 308; i++) drive(1, 16'(i), 0, 0, 0, 0);
        chk("sat_count", 32'(drop_count), 255);
        chk("sat_level", 32'(level), 8);
        drive(0, 0, 0, 1, 0, 0);
        chk("clr_count", 32'(drop_count), 0);
        chk("clr_flag", 32'(overflow), 0);
        drive(1, 16'h5555, 0, 1, 0, 0);
        chk("clr_drop_count", 32'(drop_count), 1);
        chk("clr_drop_flag", 32'(overflow), 0);

        drive(0, 0, 0, 0, 1, 16'hBEEF);
        chk("in_beef", 32'(cpu_in_port), 32'hBEEF);
        drive(0, 0, 0, 0, 0, 16'h1234);
        chk("in_hold", 32'(cpu_in_port), 32'hBEEF);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_rst_level", 32'(level), 5);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_m_valid", 32'(m_valid), 0);
        chk("async_rst_cpu_in_port", 32'(cpu_in_port), 0);
        chk("async_rst_s_ready", 32'(s_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_s_ready", 32'(s_ready), 1);
        drive(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
